// File: rtl/piso_tx_if.sv
// Handshake and serial-output bundle for piso_tx.
//   in_data    source -> tx   parallel word to transmit
//   in_valid   source -> tx   in_data is valid this cycle
//   in_ready   tx -> source   tx accepts a word this cycle
//   sout       tx -> fifo     serial data bit, LSB first
//   sout_valid tx -> fifo     sout carries a payload bit
//   tx_done    tx -> source   pulse with the last bit of a word
interface piso_tx_if #(
    parameter int unsigned WIDTH = 4
);
    logic [WIDTH-1:0] in_data;
    logic             in_valid;
    logic             in_ready;
    logic             sout;
    logic             sout_valid;
    logic             tx_done;

    // Master: word source / serial sink side.
    modport master (
        output in_data,
        output in_valid,
        input  in_ready,
        input  sout,
        input  sout_valid,
        input  tx_done
    );

    // Slave: the transmitter itself.
    modport slave (
        input  in_data,
        input  in_valid,
        output in_ready,
        output sout,
        output sout_valid,
        output tx_done
    );
endinterface

// File: rtl/piso_tx.sv
// Parallel-in, serial-out transmitter. Takes a WIDTH-bit word on a
// valid/ready handshake and sends it LSB first, one bit per clock, to a
// downstream serial-in shift register. Back-to-back words stream with no gap.
//   clk   rising-edge clock
//   rst   synchronous, active-high reset
//   bus   piso_tx_if slave: in_data/in_valid/in_ready handshake,
//         registered sout/sout_valid/tx_done
module piso_tx #(
    parameter int unsigned WIDTH = 4
) (
    input  logic       clk,
    input  logic       rst,
    piso_tx_if.slave   bus
);
    localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] CNT_PENULT = CNT_W'(WIDTH - 2);

    typedef enum logic {
        ST_IDLE,
        ST_SHIFT
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             sout_q, sout_d;
    logic             sout_valid_q, sout_valid_d;
    logic             tx_done_q, tx_done_d;

    logic             last_bit;
    logic             in_ready;
    logic             accept;

    // Ready in idle, and also during the last bit so the next word follows with no gap.
    assign last_bit = (state_q == ST_SHIFT) && (cnt_q == CNT_LAST);
    assign in_ready = !rst && ((state_q == ST_IDLE) || last_bit);
    assign accept   = bus.in_valid && in_ready;

    // Next-state and next-output logic; sout/sout_valid/tx_done describe the following cycle.
    always_comb begin
        state_d      = state_q;
        shreg_d      = shreg_q;
        cnt_d        = cnt_q;
        sout_d       = 1'b0;
        sout_valid_d = 1'b0;
        tx_done_d    = 1'b0;

        if (accept) begin
            state_d      = ST_SHIFT;
            shreg_d      = bus.in_data;
            cnt_d        = '0;
            sout_d       = bus.in_data[0];
            sout_valid_d = 1'b1;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    state_d = ST_IDLE;
                end
                ST_SHIFT: begin
                    if (last_bit) begin
                        state_d = ST_IDLE;
                        shreg_d = '0;
                        cnt_d   = '0;
                    end else begin
                        shreg_d      = shreg_q >> 1;
                        cnt_d        = cnt_q + CNT_W'(1);
                        sout_d       = shreg_q[1];
                        sout_valid_d = 1'b1;
                        // Next cycle carries the final bit of the word.
                        tx_done_d    = (cnt_q == CNT_PENULT);
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            shreg_q      <= '0;
            cnt_q        <= '0;
            sout_q       <= 1'b0;
            sout_valid_q <= 1'b0;
            tx_done_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            shreg_q      <= shreg_d;
            cnt_q        <= cnt_d;
            sout_q       <= sout_d;
            sout_valid_q <= sout_valid_d;
            tx_done_q    <= tx_done_d;
        end
    end

    assign bus.in_ready   = in_ready;
    assign bus.sout       = sout_q;
    assign bus.sout_valid = sout_valid_q;
    assign bus.tx_done    = tx_done_q;
endmodule
